// File: rtl/cpu_memory_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : cpu_memory_pkg                                                |
// | Brief   : Shared tag width, access width codes, states, alignment test. |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_memory_pkg;

  localparam int         TAG_SIZE    = 4;
  localparam logic [2:0] MEM_WIDTH_B = 3'd1;
  localparam logic [2:0] MEM_WIDTH_H = 3'd2;
  localparam logic [2:0] MEM_WIDTH_W = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ1 = 2'd1,
    ST_REQ2 = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] offset);
    return ((width == MEM_WIDTH_H) && offset[0]) ||
           ((width == MEM_WIDTH_W) && (offset != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_memory_align.sv
// ---------------------------------------------------------------------------
// | Module  : cpu_memory_align                                              |
// | Brief   : Store lane replication / byte enables and load extract-extend.|
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_memory_align
  import cpu_memory_pkg::*;
(
  input  logic [2:0]  i_st_width,
  input  logic [1:0]  i_st_offset,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_be,
  input  logic [2:0]  i_ld_width,
  input  logic [1:0]  i_ld_offset,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_ld_rdata[{i_ld_offset, 3'b000} +: 8];
  assign w_half = i_ld_rdata[{i_ld_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_st_wdata = i_st_data;
    o_st_be    = 4'b1111;
    case (i_st_width)
      MEM_WIDTH_B: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_be    = 4'b0001 << i_st_offset;
      end
      MEM_WIDTH_H: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_be    = 4'b0011 << i_st_offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_width)
      MEM_WIDTH_B: o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
      MEM_WIDTH_H: o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_memory.sv
// ---------------------------------------------------------------------------
// | Module  : cpu_memory                                                    |
// | Brief   : Pipeline memory stage; define CPU_MEMORY_MISALIGNED_EN to     |
// |           split misaligned accesses into two word transfers.            |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_memory
  import cpu_memory_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic [TAG_SIZE-1:0] i_tag,
  input  logic [4:0]          i_inst_rd,
  input  logic [31:0]         i_rd,
  input  logic [31:0]         i_pc_next,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [2:0]          i_mem_width,
  input  logic                i_mem_signed,
  input  logic [31:0]         i_mem_address,
  output logic [TAG_SIZE-1:0] o_tag,
  output logic [4:0]          o_inst_rd,
  output logic [31:0]         o_rd,
  output logic [31:0]         o_pc_next,
  output logic                o_fault,
  output logic                o_stall,
  output logic                o_bus_request,
  output logic                o_bus_rw,
  output logic [31:0]         o_bus_address,
  output logic [31:0]         o_bus_wdata,
  output logic [3:0]          o_bus_byte_enable,
  input  logic                i_bus_ready,
  input  logic [31:0]         i_bus_rdata
);

  mem_state_t          r_state;
  logic [TAG_SIZE-1:0] r_tag;
  logic [4:0]          r_inst_rd;
  logic [31:0]         r_data;
  logic [31:0]         r_pc_next;
  logic [2:0]          r_width;
  logic [1:0]          r_offset;
  logic                r_signed;
  logic                r_read;

  logic                w_accept;
  logic                w_nonmem;
  logic                w_misaligned;
  logic                w_last_beat;
  logic [31:0]         w_st_wdata;
  logic [3:0]          w_st_be;
  logic [31:0]         w_ld_rdata;
  logic [1:0]          w_ld_offset;
  logic [31:0]         w_load;

  assign w_accept     = (r_state == ST_IDLE) && !i_stall && (i_tag != o_tag);
  assign w_nonmem     = !i_mem_read && !i_mem_write;
  assign w_misaligned = is_misaligned(i_mem_width, i_mem_address[1:0]);
  assign o_stall      = (r_state != ST_IDLE);

`ifdef CPU_MEMORY_MISALIGNED_EN
  logic        r_split;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wdata_hi;
  logic [31:0] r_rdata1;
  logic [3:0]  w_mask;
  logic [7:0]  w_sp_be;
  logic [63:0] w_sp_wdata;
  logic [63:0] w_pair;

  // Shifting across a 64-bit window yields both halves of a split access at once.
  assign w_mask      = (i_mem_width == MEM_WIDTH_H) ? 4'b0011 : 4'b1111;
  assign w_sp_be     = {4'b0000, w_mask} << i_mem_address[1:0];
  assign w_sp_wdata  = {32'd0, i_rd} << {i_mem_address[1:0], 3'b000};
  assign w_pair      = {i_bus_rdata, r_rdata1};
  assign w_ld_rdata  = (r_state == ST_REQ2) ? w_pair[{r_offset, 3'b000} +: 32] : i_bus_rdata;
  assign w_ld_offset = (r_state == ST_REQ2) ? 2'b00 : r_offset;
  assign w_last_beat = (r_state == ST_REQ2) || ((r_state == ST_REQ1) && !r_split);
`else
  assign w_ld_rdata  = i_bus_rdata;
  assign w_ld_offset = r_offset;
  assign w_last_beat = (r_state == ST_REQ1);
`endif

  cpu_memory_align u_align (
    .i_st_width  (i_mem_width),
    .i_st_offset (i_mem_address[1:0]),
    .i_st_data   (i_rd),
    .o_st_wdata  (w_st_wdata),
    .o_st_be     (w_st_be),
    .i_ld_width  (r_width),
    .i_ld_offset (w_ld_offset),
    .i_ld_signed (r_signed),
    .i_ld_rdata  (w_ld_rdata),
    .o_ld_data   (w_load)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state           <= ST_IDLE;
      r_tag             <= '0;
      r_inst_rd         <= '0;
      r_data            <= '0;
      r_pc_next         <= '0;
      r_width           <= '0;
      r_offset          <= '0;
      r_signed          <= 1'b0;
      r_read            <= 1'b0;
      o_tag             <= '0;
      o_inst_rd         <= '0;
      o_rd              <= '0;
      o_pc_next         <= '0;
      o_fault           <= 1'b0;
      o_bus_request     <= 1'b0;
      o_bus_rw          <= 1'b0;
      o_bus_address     <= '0;
      o_bus_wdata       <= '0;
      o_bus_byte_enable <= '0;
`ifdef CPU_MEMORY_MISALIGNED_EN
      r_split           <= 1'b0;
      r_be_hi           <= '0;
      r_wdata_hi        <= '0;
      r_rdata1          <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tag     <= i_tag;
            r_inst_rd <= i_inst_rd;
            r_data    <= i_rd;
            r_pc_next <= i_pc_next;
            r_width   <= i_mem_width;
            r_offset  <= i_mem_address[1:0];
            r_signed  <= i_mem_signed;
            r_read    <= i_mem_read;
            if (w_nonmem) begin
              o_tag     <= i_tag;
              o_rd      <= i_rd;
              o_inst_rd <= i_inst_rd;
              o_pc_next <= i_pc_next;
              o_fault   <= 1'b0;
            end else if (w_misaligned) begin
`ifdef CPU_MEMORY_MISALIGNED_EN
              o_bus_request     <= 1'b1;
              o_bus_rw          <= i_mem_write;
              o_bus_address     <= {i_mem_address[31:2], 2'b00};
              o_bus_byte_enable <= w_sp_be[3:0];
              o_bus_wdata       <= w_sp_wdata[31:0];
              r_split           <= 1'b1;
              r_be_hi           <= w_sp_be[7:4];
              r_wdata_hi        <= w_sp_wdata[63:32];
              r_state           <= ST_REQ1;
`else
              o_tag     <= i_tag;
              o_rd      <= '0;
              o_inst_rd <= '0;
              o_pc_next <= i_pc_next;
              o_fault   <= 1'b1;
`endif
            end else begin
              o_bus_request     <= 1'b1;
              o_bus_rw          <= i_mem_write;
              o_bus_address     <= {i_mem_address[31:2], 2'b00};
              o_bus_byte_enable <= w_st_be;
              o_bus_wdata       <= w_st_wdata;
`ifdef CPU_MEMORY_MISALIGNED_EN
              r_split           <= 1'b0;
`endif
              r_state           <= ST_REQ1;
            end
          end
        end
`ifdef CPU_MEMORY_MISALIGNED_EN
        ST_REQ1: begin
          if (i_bus_ready && r_split) begin
            r_rdata1          <= i_bus_rdata;
            o_bus_address     <= o_bus_address + 32'd4;
            o_bus_byte_enable <= r_be_hi;
            o_bus_wdata       <= r_wdata_hi;
            r_state           <= ST_REQ2;
          end
        end
`endif
        default: ;
      endcase

      if (w_last_beat && i_bus_ready) begin
        o_tag         <= r_tag;
        o_rd          <= r_read ? w_load : r_data;
        o_inst_rd     <= r_inst_rd;
        o_pc_next     <= r_pc_next;
        o_fault       <= 1'b0;
        o_bus_request <= 1'b0;
        r_state       <= ST_IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/cpu_memory.md
# cpu_memory

Memory stage of the Rv32H pipeline. It sits directly after the execute stage and consumes that stage's memory request: `o_mem_read`, `o_mem_write`, `o_mem_width`, `o_mem_signed`, `o_mem_address` and `o_rd` (the store data or ALU result). It drives a word-wide data bus with byte enables, aligns and extends load data, and forwards the result, tagged, to writeback. Tag-based handshake is identical to the rest of the pipeline: a new instruction is present when `i_tag != o_tag`.

## Interface
- Parameters: none. Tag width comes from the shared `TAG_SIZE`.
- `i_clock` in 1 — clock, all logic on rising edge.
- `i_reset` in 1 — synchronous, active-high.
- `i_stall` in 1 — downstream stall; blocks acceptance of a new tag.
- `i_tag` in `TAG_SIZE` — upstream instruction tag.
- `i_inst_rd` in 5 — destination register index.
- `i_rd` in 32 — ALU result, or store data when `i_mem_write`.
- `i_pc_next` in 32 — next PC, passed through.
- `i_mem_read`, `i_mem_write` in 1 each — access request; never both high.
- `i_mem_width` in 3 — 1 = byte, 2 = half, 4 = word.
- `i_mem_signed` in 1 — sign-extend loads.
- `i_mem_address` in 32 — byte address.
- `o_tag` out `TAG_SIZE` — tag of the last completed instruction.
- `o_inst_rd` out 5, `o_rd` out 32, `o_pc_next` out 32 — writeback payload.
- `o_fault` out 1 — the completed instruction was a misaligned access.
- `o_stall` out 1 — stage busy (state != IDLE).
- `o_bus_request` out 1, `o_bus_rw` out 1 (1 = write), `o_bus_address` out 32 (always word-aligned), `o_bus_wdata` out 32, `o_bus_byte_enable` out 4.
- `i_bus_ready` in 1, `i_bus_rdata` in 32.

## Operation
- **States:**
  - IDLE: accepts when `!i_stall && i_tag != o_tag`.
  - REQ1: first bus access.
  - REQ2: second access of a split misaligned access (configuration-dependent).
- **Accept:** latch tag, rd index, data, address, width, signed and pc_next. Later changes on the inputs are ignored until completion.
- **Non-memory instruction** (neither read nor write): complete at the accept edge.
  - `o_rd <= i_rd`, `o_inst_rd`, `o_pc_next` and `o_tag` updated, `o_fault <= 0`.
  - State stays IDLE.
- **Aligned access:** go to REQ1.
  - `o_bus_address = {addr[31:2],2'b00}`.
  - Byte: BE = 0001 << addr[1:0].
  - Half: BE = 0011 << addr[1:0].
  - Word: BE = 1111.
  - Store data is replicated across lanes: byte → {4{d[7:0]}}, half → {2{d[15:0]}}, word → d.
- **Misalignment:** half with addr[0]=1, or word with addr[1:0]≠0.
- **Load result:** shift `i_bus_rdata` right by 8×addr[1:0], then zero- or sign-extend from bit 7 or bit 15 per width and `signed`. Word loads are unmodified.
- **Store completion:** `o_rd <= latched data` (don't-care to writeback); `o_inst_rd` as latched.
- **Completion:** on the edge where REQ1 (or REQ2) samples `i_bus_ready=1`.
  - Update `o_tag`, `o_rd`, `o_inst_rd`, `o_pc_next`, `o_fault`.
  - `o_bus_request <= 0`; state → IDLE.

## Timing
- **Reset values:** state IDLE; every output 0. A reset mid-transaction aborts it: `o_bus_request` is low after the reset edge and no completion is reported.
- **Non-memory instruction:** 1 cycle latency (outputs valid the cycle after accept).
- **Bus:**
  - `o_bus_request` and all `o_bus_*` are registered and held stable until `i_bus_ready` is sampled high.
  - Ready with request high = one transfer.
  - Ready while request is low is ignored.
- **Memory access, zero-wait bus:** request high in cycle N+1 after accept edge N; completion visible in N+2. Each wait cycle adds 1.
- **Split access:** request stays high continuously. Address, BE and wdata change to the second word on the edge after the first ready.
- **`o_stall`:** high from the cycle after accept until the cycle completion becomes visible.
- **`i_stall`:** affects only acceptance; an in-flight access always completes.

## Configuration
- **`CPU_MEMORY_MISALIGNED_EN` defined:** misaligned accesses split into two word accesses at A&~3 and (A&~3)+4, with k = addr[1:0].
  - First access BE = (mask<<k)[3:0], wdata = d<<8k, where mask = 0011 (half) or 1111 (word).
  - Second access BE = mask>>(4−k), wdata = d>>(32−8k).
  - Load = (rdata1>>8k) | (rdata2<<(32−8k)), then extended as for an aligned load.
  - `o_fault` is tied to 0.
- **Undefined:** a misaligned access performs no bus transfer. It completes at the accept edge with `o_fault=1`, `o_inst_rd=0`, `o_rd=0`. REQ2 does not exist.

## Structure
- **Shared defines header:** `TAG_SIZE`, width encodings MEM_WIDTH_B/H/W (1/2/4), state encodings.
- **Sub-module `cpu_memory_align`** (combinational): store lane replication, BE generation and load extract/extend. Instantiated once; split merge stays in the parent.

## Test plan
1. **Reset:** assert `i_reset` during REQ1 with ready held low → `o_bus_request=0`, `o_tag=0`, state IDLE after the edge.
2. **Pass-through:** tag 1, `i_rd=0x1234`, no access → `o_rd=0x1234`, `o_tag=1` the next cycle; no bus request.
3. **Signed byte load:** LB at 0x1003, `rdata=0x80FF_FF7F` → BE 1000, address 0x1000, `o_rd=0xFFFF_FF80`. Same access unsigned → `0x0000_0080`.
4. **Halfword store:** SH 0xBEEF at 0x2002 with 3 wait cycles → `wdata=0xBEEF_BEEF`, BE 1100, request held 4 cycles, `o_stall` high throughout, completion one cycle after ready.
5. **Misaligned word load at 0x3001, macro on:** `rdata1=0x4433_2211`, `rdata2=0x8877_6655` → accesses 0x3000 (BE 1110) then 0x3004 (BE 0001), `o_rd=0x5544_3322`. Macro off → no request, `o_fault=1`, `o_inst_rd=0`.
6. **Back-to-back with downstream stall:** `i_stall=1` with a new tag pending → no acceptance. Release → accepted next edge and requests issue in order.
